sdram_cp_feeder: RTL and testbench

Page-buffering source for the SDRAM controller's copy port. It accepts a stream of 16-bit words from the ROM loader into a ping-pong pair of 512-word pages. Each full (or flushed) page is handed to the controller as one copy request, and the block supplies `cpdin` in lock-step with the controller's `cprd` strobe. It sits between the loader and the `cp*` ports of the SDRAM controller, one instance per SDRAM chip.

---
 rtl/sdram_cp_pkg.sv | 11 +
 rtl/sdram_cp_pagebuf.sv | 20 ++
 rtl/sdram_cp_feeder.sv | 146 ++++++++++++++
 tb/tb_sdram_cp_feeder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cp_pkg.sv
// rtl/sdram_cp_pkg.sv - shared constants and types for the SDRAM copy-port feeder
package sdram_cp_pkg;
  localparam int          CP_WORDS       = 512;
  localparam logic [15:0] CP_PAD_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_STREAM
  } cp_state_t;
endpackage

// File: rtl/sdram_cp_pagebuf.sv
// rtl/sdram_cp_pagebuf.sv - 1024x16 simple dual-port page RAM, synchronous read
// Two 512-word pages addressed by the top address bit; no reset so it maps onto block RAM.
module sdram_cp_pagebuf (
  input  logic        i_clk,
  input  logic        i_wr_en,
  input  logic [9:0]  i_wr_addr,
  input  logic [15:0] i_wr_data,
  input  logic [9:0]  i_rd_addr,
  output logic [15:0] o_rd_data
);
  logic [15:0] r_mem [0:1023];
  logic [15:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/sdram_cp_feeder.sv
// rtl/sdram_cp_feeder.sv - ping-pong page buffer feeding the SDRAM controller copy port
// Optional stream checksum: SDRAM_CP_FEEDER_CSUM_EN.
module sdram_cp_feeder
  import sdram_cp_pkg::*;
#(
  parameter logic [15:0] PAD = CP_PAD_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_nreset,
  input  logic        i_ld_start,
  input  logic [26:1] i_ld_base,
  input  logic        i_ld_wr,
  input  logic [15:0] i_ld_data,
  input  logic        i_ld_flush,
  output logic        o_ld_ready,
  output logic        o_busy,
  output logic        o_cpsel,
  output logic        o_cpreq,
  output logic [26:1] o_cpaddr,
  output logic [15:0] o_cpdin,
  input  logic        i_cprd,
  input  logic        i_cpbusy,
  output logic [15:0] o_csum
);
  cp_state_t        r_state, w_state_nxt;
  logic             r_wr_buf, r_rd_buf;
  logic [8:0]       r_wr_ptr;
  logic [9:0]       r_rd_cnt;
  logic [1:0]       r_full, w_full_nxt;
  logic [1:0][9:0]  r_fill_len;
  logic [1:0][26:1] r_page_addr;
  logic [26:1]      r_next_addr, r_cpaddr;
  logic [15:0]      r_cpdin;

  logic        w_busy, w_start, w_ld_ready, w_accept, w_wrap, w_close;
  logic [8:0]  w_ptr_inc, w_ptr_after;
  logic [9:0]  w_close_len, w_rd_cnt_nxt;
  logic        w_load, w_release, w_launch, w_rd_buf_nxt;
  logic [15:0] w_rd_data, w_load_word;
  logic        w_unused;

  assign w_busy      = (|r_full) | (r_state != S_IDLE);
  assign w_start     = i_ld_start & ~w_busy;
  assign w_ld_ready  = ~r_full[r_wr_buf];
  assign w_accept    = i_ld_wr & w_ld_ready & ~w_start;
  assign w_ptr_inc   = r_wr_ptr + 9'd1;
  assign w_wrap      = w_accept & (r_wr_ptr == 9'(CP_WORDS - 1));
  assign w_ptr_after = w_accept ? w_ptr_inc : r_wr_ptr;
  // A flush after a page-completing word sees w_ptr_after==0 and does nothing.
  assign w_close     = ~w_start & (w_wrap | (i_ld_flush & (w_ptr_after != 9'd0)));
  assign w_close_len = w_wrap ? 10'(CP_WORDS) : {1'b0, w_ptr_after};

  always_ff @(posedge i_clk) begin
    if (!i_nreset) r_state <= S_IDLE;
    else           r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (r_full[r_rd_buf]) w_state_nxt = S_REQ;
      S_REQ:    if (i_cprd)           w_state_nxt = S_STREAM;
      S_STREAM: if (!i_cprd)          w_state_nxt = S_IDLE;
      default:                        w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_launch     = (r_state == S_IDLE) & r_full[r_rd_buf];
    w_load       = i_cprd & (r_state != S_IDLE);
    w_release    = (r_state == S_STREAM) & ~i_cprd;
    w_rd_buf_nxt = w_release ? ~r_rd_buf : r_rd_buf;
    w_rd_cnt_nxt = r_rd_cnt;
    if ((r_state == S_IDLE) || w_release) w_rd_cnt_nxt = 10'd0;
    else if (w_load)                      w_rd_cnt_nxt = r_rd_cnt + 10'd1;
    w_full_nxt = r_full;
    if (w_release) w_full_nxt[r_rd_buf] = 1'b0;
    if (w_close)   w_full_nxt[r_wr_buf] = 1'b1;
  end

  // RAM is read at the next pointer so its registered output is ready when cprd loads it.
  sdram_cp_pagebuf u_pagebuf (
    .i_clk     (i_clk),
    .i_wr_en   (w_accept),
    .i_wr_addr ({r_wr_buf, r_wr_ptr}),
    .i_wr_data (i_ld_data),
    .i_rd_addr ({w_rd_buf_nxt, w_rd_cnt_nxt[8:0]}),
    .o_rd_data (w_rd_data)
  );

  assign w_load_word = ({1'b0, r_rd_cnt[8:0]} < r_fill_len[r_rd_buf]) ? w_rd_data : PAD;

  always_ff @(posedge i_clk) begin
    if (!i_nreset) begin
      r_wr_buf    <= 1'b0;
      r_rd_buf    <= 1'b0;
      r_wr_ptr    <= '0;
      r_rd_cnt    <= '0;
      r_full      <= '0;
      r_fill_len  <= '0;
      r_page_addr <= '0;
      r_next_addr <= '0;
      r_cpaddr    <= '0;
      r_cpdin     <= '0;
    end else begin
      if (w_start) begin
        r_next_addr <= i_ld_base;
        r_wr_ptr    <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= w_ptr_inc;
        if (w_close) begin
          r_wr_ptr              <= '0;
          r_fill_len[r_wr_buf]  <= w_close_len;
          r_page_addr[r_wr_buf] <= r_next_addr;
          r_next_addr           <= r_next_addr + 26'(CP_WORDS);
          r_wr_buf              <= ~r_wr_buf;
        end
      end
      r_full   <= w_full_nxt;
      r_rd_cnt <= w_rd_cnt_nxt;
      r_rd_buf <= w_rd_buf_nxt;
      if (w_launch) r_cpaddr <= r_page_addr[r_rd_buf];
      if (w_load)   r_cpdin  <= w_load_word;
    end
  end

`ifdef SDRAM_CP_FEEDER_CSUM_EN
  logic [15:0] r_csum;
  always_ff @(posedge i_clk) begin
    if (!i_nreset)                   r_csum <= '0;
    else if (w_start)                r_csum <= '0;
    else if (w_load && !r_rd_cnt[9]) r_csum <= r_csum + w_load_word;
  end
  assign o_csum = r_csum;
`else
  assign o_csum = '0;
`endif

  assign w_unused   = i_cpbusy;
  assign o_ld_ready = w_ld_ready;
  assign o_busy     = w_busy;
  assign o_cpsel    = (r_state != S_IDLE);
  assign o_cpreq    = (r_state == S_REQ);
  assign o_cpaddr   = r_cpaddr;
  assign o_cpdin    = r_cpdin;
endmodule

// File: tb/tb_sdram_cp_feeder.sv
// tb/tb_sdram_cp_feeder.sv - directed self-checking bench for sdram_cp_feeder
module tb_sdram_cp_feeder;
  localparam logic [15:0] PAD = 16'hFFFF;
`ifdef SDRAM_CP_FEEDER_CSUM_EN
  localparam logic [15:0] EXP_CSUM = 16'hFF00;
`else
  localparam logic [15:0] EXP_CSUM = 16'h0000;
`endif

  logic        clk = 1'b0;
  logic        nreset, ld_start, ld_wr, ld_flush, cprd, cpbusy;
  logic [26:1] ld_base;
  logic [15:0] ld_data;
  logic        ld_ready, busy, cpsel, cpreq;
  logic [26:1] cpaddr;
  logic [15:0] cpdin, csum;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          drops;

  always #5 clk = ~clk;

  sdram_cp_feeder dut (
    .i_clk      (clk),
    .i_nreset   (nreset),
    .i_ld_start (ld_start),
    .i_ld_base  (ld_base),
    .i_ld_wr    (ld_wr),
    .i_ld_data  (ld_data),
    .i_ld_flush (ld_flush),
    .o_ld_ready (ld_ready),
    .o_busy     (busy),
    .o_cpsel    (cpsel),
    .o_cpreq    (cpreq),
    .o_cpaddr   (cpaddr),
    .o_cpdin    (cpdin),
    .i_cprd     (cprd),
    .i_cpbusy   (cpbusy),
    .o_csum     (csum)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic write_words(input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) begin
      ld_wr   = 1'b1;
      ld_data = base + 16'(i);
      tick();
    end
    ld_wr = 1'b0;
  endtask

  task automatic start_load(input logic [26:1] base);
    ld_base  = base;
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
  endtask

  task automatic wait_req(input string tag);
    int n = 0;
    while (cpreq !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_req"}, 32'(cpreq), 32'd1);
  endtask

  // Controller model: 513 cprd cycles, word k checked after the (k+1)th load edge.
  task automatic serve(input string tag, input logic [26:1] exp_addr,
                       input logic [15:0] base, input int len);
    logic [15:0] e;
    wait_req(tag);
    chk({tag, "_addr"}, 32'(cpaddr), 32'(exp_addr));
    chk({tag, "_sel"}, 32'(cpsel), 32'd1);
    cprd   = 1'b1;
    cpbusy = 1'b1;
    for (int k = 0; k < 513; k++) begin
      tick();
      if (k == 0) chk({tag, "_req_drop"}, 32'(cpreq), 32'd0);
      if (k < 512) begin
        e = (k < len) ? base + 16'(k) : PAD;
        chk({tag, "_word"}, 32'(cpdin), 32'(e));
      end
    end
    cprd = 1'b0;
    tick();
    cpbusy = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nreset = 1'b0; ld_start = 1'b0; ld_wr = 1'b0; ld_flush = 1'b0;
    cprd = 1'b0; cpbusy = 1'b0; ld_base = '0; ld_data = '0;
    repeat (3) tick();
    chk("rst_cpreq", 32'(cpreq), 32'd0);
    chk("rst_cpsel", 32'(cpsel), 32'd0);
    chk("rst_cpaddr", 32'(cpaddr), 32'd0);
    chk("rst_cpdin", 32'(cpdin), 32'd0);
    chk("rst_csum", 32'(csum), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd1);
    nreset = 1'b1;
    tick();

    // Full page 0..511, request timing and checksum
    start_load(26'h0000400);
    write_words(512, 16'h0000);
    chk("t1_req_early", 32'(cpreq), 32'd0);
    chk("t1_busy", 32'(busy), 32'd1);
    tick();
    chk("t1_req_rise", 32'(cpreq), 32'd1);
    serve("t1", 26'h0000400, 16'h0000, 512);
    chk("t1_csum", 32'(csum), 32'(EXP_CSUM));
    chk("t1_idle_busy", 32'(busy), 32'd0);

    // Partial page: A,B,C then flush, padded tail
    write_words(3, 16'hA000);
    ld_flush = 1'b1;
    tick();
    ld_flush = 1'b0;
    chk("t2_req_early", 32'(cpreq), 32'd0);
    tick();
    chk("t2_req_rise", 32'(cpreq), 32'd1);
    serve("t2", 26'h0000600, 16'hA000, 3);

    // Flush on an empty page does nothing
    ld_flush = 1'b1;
    tick();
    ld_flush = 1'b0;
    repeat (3) tick();
    chk("t2_empty_flush_req", 32'(cpreq), 32'd0);
    chk("t2_empty_flush_busy", 32'(busy), 32'd0);

    // Flush coinciding with the 512th word: one request only
    write_words(511, 16'h4000);
    ld_wr = 1'b1; ld_data = 16'h4000 + 16'd511; ld_flush = 1'b1;
    tick();
    ld_wr = 1'b0; ld_flush = 1'b0;
    serve("t3", 26'h0000800, 16'h4000, 512);
    repeat (4) tick();
    chk("t3_no_extra_req", 32'(cpreq), 32'd0);
    chk("t3_no_extra_busy", 32'(busy), 32'd0);

    // Stalled controller: 1100 words, the last 76 dropped
    start_load(26'h0010000);
    write_words(1024, 16'h1000);
    chk("t4_ready_low", 32'(ld_ready), 32'd0);
    chk("t4_req_pending", 32'(cpreq), 32'd1);
    write_words(76, 16'hE000);
    serve("t4a", 26'h0010000, 16'h1000, 512);
    chk("t4_ready_back", 32'(ld_ready), 32'd1);
    chk("t4_b2b_gap", 32'(cpreq), 32'd0);
    tick();
    chk("t4_b2b_rise", 32'(cpreq), 32'd1);
    serve("t4b", 26'h0010200, 16'h1200, 512);
    repeat (4) tick();
    chk("t4_dropped_req", 32'(cpreq), 32'd0);
    chk("t4_dropped_busy", 32'(busy), 32'd0);

    // 1024 words without gaps while the controller streams
    start_load(26'h0000400);
    drops = 0;
    fork
      begin
        for (int i = 0; i < 1024; i++) begin
          if (ld_ready !== 1'b1) drops++;
          ld_wr   = 1'b1;
          ld_data = 16'h3000 + 16'(i);
          tick();
        end
        ld_wr = 1'b0;
      end
      begin
        serve("t5a", 26'h0000400, 16'h3000, 512);
        serve("t5b", 26'h0000600, 16'h3200, 512);
      end
    join
    chk("t5_ready_never_drops", 32'(drops), 32'd0);
    chk("t5_busy_done", 32'(busy), 32'd0);

    // Checksum after a fresh load, then reset mid-stream
    start_load(26'h0000000);
    write_words(512, 16'h0000);
    serve("t6", 26'h0000000, 16'h0000, 512);
    chk("t6_csum", 32'(csum), 32'(EXP_CSUM));
    write_words(512, 16'h0000);
    wait_req("t6b");
    cprd = 1'b1;
    cpbusy = 1'b1;
    repeat (200) tick();
    nreset = 1'b0;
    tick();
    chk("t6_rst_cpreq", 32'(cpreq), 32'd0);
    chk("t6_rst_cpsel", 32'(cpsel), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_ready", 32'(ld_ready), 32'd1);
    chk("t6_rst_cpdin", 32'(cpdin), 32'd0);
    chk("t6_rst_cpaddr", 32'(cpaddr), 32'd0);
    chk("t6_rst_csum", 32'(csum), 32'd0);
    cprd = 1'b0;
    cpbusy = 1'b0;
    nreset = 1'b1;
    repeat (3) tick();
    chk("t6_post_rst_req", 32'(cpreq), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
